data_cache_ctrl: RTL

- Sequencing controller for the direct-mapped data cache (256 lines of {valid, tag, data}).
- Accepts single-word CPU read/write requests, performs the tag lookup, and fetches misses from DRAM before filling the line.
- Writes are write-through: the line is updated and the word is forwarded to DRAM.
- Sits between the CPU load/store port, the data cache array and the DRAM request port. Also owns cache flush and hit/miss statistics.

---
 rtl/data_cache_pkg.sv | 39 +++
 rtl/data_cache_ctrl_sat_counter.sv | 34 +++
 rtl/data_cache_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/data_cache_pkg.sv
//------------------------------------------------------------------------------
// Module   : data_cache_pkg
// Purpose  : Shared types, default sizes and address helpers for the data cache
//            controller.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package data_cache_pkg;

    localparam int C_INDEX_COUNT = 256;
    localparam int C_DATA_W      = 11;
    localparam int C_TAG_W       = 20;
    localparam int C_IDX_W       = $clog2(C_INDEX_COUNT);
    localparam int C_ADDR_W      = C_TAG_W + C_IDX_W;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FLUSH  = 3'd1,
        ST_LOOKUP = 3'd2,
        ST_MEM_RD = 3'd3,
        ST_FILL   = 3'd4,
        ST_MEM_WR = 3'd5,
        ST_RESP   = 3'd6
    } ctrl_state_e;

    typedef struct packed {
        logic [C_TAG_W-1:0] tag;
        logic [C_IDX_W-1:0] index;
    } addr_split_t;

    // Address layout is {tag, index}, so the split is a plain reinterpretation.
    function automatic addr_split_t split_addr(input logic [C_ADDR_W-1:0] addr);
        return addr_split_t'(addr);
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_cache_ctrl_sat_counter.sv
//------------------------------------------------------------------------------
// Module   : sat_counter
// Purpose  : Up-counter that sticks at all-ones; used for hit/miss statistics.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/data_cache_ctrl.sv
//------------------------------------------------------------------------------
// Module   : data_cache_ctrl
// Purpose  : Request sequencer for a direct-mapped, write-through, single-word
//            line data cache with DRAM refill, flush and hit/miss statistics.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module data_cache_ctrl
    import data_cache_pkg::*;
#(
    parameter  int INDEX_COUNT = C_INDEX_COUNT,
    parameter  int DATA_W      = C_DATA_W,
    parameter  int TAG_W       = C_TAG_W,
    parameter  int CNT_W       = 16,
    localparam int IDX_W       = $clog2(INDEX_COUNT),
    localparam int ADDR_W      = TAG_W + IDX_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_req_valid,
    output logic                      cpu_req_ready,
    input  logic                      cpu_req_we,
    input  logic [ADDR_W-1:0]         cpu_req_addr,
    input  logic [DATA_W-1:0]         cpu_req_wdata,
    output logic                      cpu_rsp_valid,
    input  logic                      cpu_rsp_ready,
    output logic [DATA_W-1:0]         cpu_rsp_rdata,
    input  logic                      flush_req,
    output logic                      cache_rst,
    output logic                      cache_enable,
    output logic                      cache_rd_wr_sel,
    output logic [IDX_W-1:0]          cache_index_sel,
    output logic [TAG_W+DATA_W:0]     cache_write_index,
    output logic                      cache_hit_miss,
    input  logic [TAG_W-1:0]          cache_tag,
    input  logic                      cache_valid,
    input  logic [DATA_W-1:0]         cache_data_io,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic                      mem_ack,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [CNT_W-1:0]          hit_count,
    output logic [CNT_W-1:0]          miss_count
);

    ctrl_state_e       r_state;
    ctrl_state_e       w_next_state;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_hit_miss;

    logic [TAG_W-1:0]  w_tag;
    logic [IDX_W-1:0]  w_idx;
    logic              w_hit;
    logic              w_lookup;

    assign w_tag = r_addr[ADDR_W-1 -: TAG_W];
    assign w_idx = r_addr[IDX_W-1:0];
    assign w_hit = cache_valid && (cache_tag == w_tag);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rsp_data <= '0;
            r_hit_miss <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (!flush_req && cpu_req_valid) begin
                        r_we    <= cpu_req_we;
                        r_addr  <= cpu_req_addr;
                        r_wdata <= cpu_req_wdata;
                    end
                end
                ST_LOOKUP: begin
                    r_hit_miss <= w_hit;
                    if (r_we) begin
                        r_rsp_data <= '0;
                    end else if (w_hit) begin
                        r_rsp_data <= cache_data_io;
                    end
                end
                ST_MEM_RD: begin
                    if (mem_ack) begin
                        r_rsp_data <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next_state      = r_state;
        w_lookup          = 1'b0;
        cpu_req_ready     = 1'b0;
        cpu_rsp_valid     = 1'b0;
        cpu_rsp_rdata     = '0;
        cache_rst         = 1'b0;
        cache_enable      = 1'b0;
        cache_rd_wr_sel   = 1'b0;
        cache_write_index = '0;
        mem_req           = 1'b0;
        mem_we            = 1'b0;
        mem_addr          = '0;
        mem_wdata         = '0;
        case (r_state)
            ST_IDLE: begin
                // Held low while reset is asserted so nothing is accepted then.
                cpu_req_ready = rst;
                if (flush_req) begin
                    w_next_state = ST_FLUSH;
                end else if (cpu_req_valid) begin
                    w_next_state = ST_LOOKUP;
                end
            end
            ST_FLUSH: begin
                cache_rst    = 1'b1;
                w_next_state = ST_IDLE;
            end
            ST_LOOKUP: begin
                w_lookup = 1'b1;
                if (r_we) begin
                    cache_enable      = 1'b1;
                    cache_rd_wr_sel   = 1'b1;
                    cache_write_index = {1'b1, w_tag, r_wdata};
                    w_next_state      = ST_MEM_WR;
                end else if (w_hit) begin
                    w_next_state = ST_RESP;
                end else begin
                    w_next_state = ST_MEM_RD;
                end
            end
            ST_MEM_RD: begin
                mem_req  = 1'b1;
                mem_addr = r_addr;
                if (mem_ack) begin
                    w_next_state = ST_FILL;
                end
            end
            ST_FILL: begin
                cache_enable      = 1'b1;
                cache_rd_wr_sel   = 1'b1;
                cache_write_index = {1'b1, w_tag, r_rsp_data};
                w_next_state      = ST_RESP;
            end
            ST_MEM_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
                if (mem_ack) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                cpu_rsp_valid = 1'b1;
                cpu_rsp_rdata = r_rsp_data;
                if (cpu_rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign cache_index_sel = w_idx;
    assign cache_hit_miss  = r_hit_miss;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (w_lookup && w_hit),
        .count (hit_count)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (w_lookup && !w_hit),
        .count (miss_count)
    );

endmodule

`default_nettype wire
